// File: rtl/five_bit_lock.sv
// rtl/five_bit_lock.sv - serial combination lock with overlapping (KMP) match detection
module five_bit_lock #(
    parameter logic [4:0] CODE     = 5'b11100,
    parameter int         CODE_LEN = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    output logic l
);

    // State value = number of leading CODE bits matched; CODE_LEN means UNLOCK.
    localparam int SW = $clog2(CODE_LEN + 1);
    typedef logic [SW-1:0] state_t;

    localparam state_t MATCH0 = '0;
    localparam state_t UNLOCK = state_t'(CODE_LEN);

    // Bit i of the combination in entry order (i = 0 is entered first).
    function automatic logic code_bit(input int i);
        logic [CODE_LEN-1:0] v;
        v = CODE[CODE_LEN-1:0] >> (CODE_LEN - 1 - i);
        return v[0];
    endfunction

    // Longest CODE prefix that is a suffix of (first k CODE bits, then b).
    function automatic int kmp_next(input int k, input logic b);
        int   best;
        int   p;
        logic ok;
        logic cb;
        best = 0;
        for (int j = 1; j <= CODE_LEN; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < CODE_LEN; i++) begin
                    if (i < j) begin
                        p  = k + 1 - j + i;
                        cb = (p < k) ? code_bit(p) : b;
                        if (cb != code_bit(i)) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = j;
                end
            end
        end
        return best;
    endfunction

    state_t next_on0 [CODE_LEN+1];
    state_t next_on1 [CODE_LEN+1];

    // Fallback table folds to constants at elaboration.
    for (genvar k = 0; k <= CODE_LEN; k++) begin : g_tab
        assign next_on0[k] = state_t'(kmp_next(k, 1'b0));
        assign next_on1[k] = state_t'(kmp_next(k, 1'b1));
    end

    state_t state_q, state_d;
    logic   l_q, l_d;

    // Next-state: follow the fallback table; unreachable encodings recover to MATCH0.
    always_comb begin
        state_d = MATCH0;
        l_d     = 1'b0;
        if (state_q <= UNLOCK) begin
            state_d = a ? next_on1[state_q] : next_on0[state_q];
        end
        l_d = (state_d == UNLOCK);
    end

    // State and unlock flag registers; reset clears progress immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MATCH0;
            l_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
        end
    end

    assign l = l_q;

endmodule

// File: tb/tb_five_bit_lock.sv
// tb/tb_five_bit_lock.sv - directed self-checking bench for five_bit_lock
module tb_five_bit_lock;

    logic clk;
    logic reset;
    logic a;
    logic l;

    int n_cmp;
    int n_bad;

    five_bit_lock dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .l     (l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one bit at the falling edge, then check l just after the rising edge.
    task automatic step(input string tag, input logic b, input logic exp_l);
        @(negedge clk);
        a = b;
        @(posedge clk);
        #1;
        check(tag, l, exp_l);
    endtask

    // bits/exp are entered MSB-first over n cycles.
    task automatic run_seq(input string tag, input int n,
                           input logic [15:0] bits, input logic [15:0] exp);
        logic [15:0] bv;
        logic [15:0] ev;
        bv = bits;
        ev = exp;
        for (int i = 0; i < n; i++) begin
            step($sformatf("%s[%0d]", tag, i), bv[n-1-i], ev[n-1-i]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        a     = 1'b0;
        reset = 1'b0;

        // Reset held with a toggling: l must stay low.
        #1;
        check("reset_init", l, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = ~a;
            @(posedge clk);
            #1;
            check($sformatf("reset_hold[%0d]", i), l, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;

        run_seq("correct",   5,  16'b11100,       16'b00001);
        run_seq("after",     1,  16'b0,           16'b0);
        run_seq("near_miss", 5,  16'b11000,       16'b00000);
        run_seq("retry",     5,  16'b11100,       16'b00001);
        run_seq("retry_end", 1,  16'b0,           16'b0);
        run_seq("fallback",  6,  16'b111100,      16'b000001);
        run_seq("fb_end",    1,  16'b0,           16'b0);
        run_seq("b2b",       10, 16'b1110011100,  16'b0000100001);
        run_seq("b2b_end",   1,  16'b0,           16'b0);

        // Async reset while l is high: must drop before the next edge.
        run_seq("pre_async", 5,  16'b11100,       16'b00001);
        #2;
        reset = 1'b0;
        #1;
        check("async_drop", l, 1'b0);
        @(posedge clk);
        #1;
        check("async_held", l, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Reset mid-sequence discards the partial match.
        run_seq("partial",   3,  16'b111,         16'b000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_seq("discard",   2,  16'b00,          16'b00);
        run_seq("post_rst",  5,  16'b11100,       16'b00001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
